br_issue_queue: RTL and testbench
=================================

Name: br_issue_queue

Overview:
In-order issue queue for branch/jump/AUIPC uops. It sits between rename/dispatch and the branch functional unit.
- Holds each uop until both source operands have been captured, either from dispatch or from CDB wakeup.
- Issues uops strictly oldest-first, one per cycle, on a valid/ready handshake into the branch FU input register.
- A global flush empties it.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2.
PHY_W, 6, physical register tag width.
ROB_W, 5, ROB id width.
NUM_CDB, 2, number of CDB broadcast ports.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  mispredict/exception flush; empties queue
disp_valid  in  1  dispatch uop present
disp_ready  out  1  queue can accept (registered: count != DEPTH)
disp_pc  in  32  uop PC
disp_imm  in  32  immediate
disp_opcode  in  4  branch FU opcode (BEQ..JALR, AUIPC)
disp_rob_id  in  ROB_W  ROB id
disp_rd_arch  in  5  architectural rd
disp_rd_phy  in  PHY_W  physical rd
disp_pred_taken  in  1  predicted direction
disp_pred_target  in  32  predicted target
disp_rs1_phy / disp_rs2_phy  in  PHY_W each  source tags
disp_rs1_rdy / disp_rs2_rdy  in  1 each  source value valid at dispatch
disp_rs1_val / disp_rs2_val  in  32 each  source values (meaningful when rdy)
cdb_valid  in  NUM_CDB  per-bus valid
cdb_phy  in  NUM_CDB*PHY_W  per-bus tag, bus i at [i*PHY_W +: PHY_W]
cdb_val  in  NUM_CDB*32  per-bus value
iss_valid  out  1  head entry issuable
iss_ready  in  1  FU accepts
iss_* (pc, imm, opcode, rob_id, rd_arch, rd_phy, pred_taken, pred_target, rs1_val, rs2_val)  out  as dispatch widths  head payload
perf_full_cycles  out  32  see Optional Feature
perf_stall_cycles  out  32  see Optional Feature

Behaviour:
- Storage:
  - Circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
  - count is log2(DEPTH)+1 bits.
  - Each entry holds a valid bit, two source ready bits and the captured values.
- Reset: head = tail = count = 0; all entry valid bits = 0.
  - Outputs after reset: disp_ready = 1, iss_valid = 0, perf counters = 0.
- Dispatch: when disp_valid && disp_ready, write entry[tail] and advance tail next edge.
  - Source with phy == 0 is forced ready with value 0.
- Wakeup: each cycle, every valid entry with a not-ready source compares its tag against all valid CDB buses.
  - On a match, set ready and capture the value.
  - Same-cycle bypass: a dispatching uop whose not-ready tag matches a CDB bus in that cycle is written ready with the CDB value.
  - Multiple buses matching the same tag: lowest bus index wins.
- Issue:
  - iss_valid = entry[head].valid && rs1_rdy && rs2_rdy, combinational from stored state.
  - Payload is driven from entry[head].
  - On iss_valid && iss_ready: clear entry[head].valid and advance head.
  - Minimum latency dispatch->issue is 1 cycle, when operands are ready at dispatch.
  - Younger ready entries never bypass a stalled head.
- Simultaneous dispatch + issue: count is unchanged.
  - disp_ready is computed from registered count, so when full, dispatch is blocked even if the head issues that cycle. No full-queue bypass.
- Empty: iss_valid = 0; payload is don't-care.
- Flush: highest priority.
  - Next edge: all valid bits = 0, head = tail = count = 0.
  - A dispatch, wakeup or issue handshake in the flush cycle is discarded; the FU ignores the issue via its own flush.
- disp_ready, iss_valid and head/tail/count never take X after reset.

Optional Feature:
Macro BR_ISSUE_QUEUE_PERF_EN.
- Defined: two 32-bit wrapping counters, cleared by rst (not by flush).
  - perf_full_cycles increments each cycle count == DEPTH.
  - perf_stall_cycles increments each cycle the head is valid but not ready (operand wait).
- Undefined: counters are not instantiated; both outputs are tied to 0.

Test Plan:
- Dispatch BEQ pc=0x100, both rdy, iss_ready=1 -> iss_valid in the next cycle with pc=0x100; queue empty after.
- Dispatch JALR rs1_phy=12 not ready; CDB bus1 phy=12 val=0x2000 two cycles later -> iss_valid the cycle after the wakeup, iss_rs1_val=0x2000.
- Dispatch rs2_phy=7 not ready in the same cycle that CDB bus0 broadcasts phy=7 val=0x55 -> entry issues next cycle with rs2_val=0x55.
- Head waits on a tag; a younger entry is ready -> no issue until the head wakes; then both issue in order on consecutive cycles.
- Fill 8 entries with iss_ready=0 -> disp_ready=0; one issue -> disp_ready=1 the next cycle. Run 20 alloc/issue pairs to check pointer wrap.
- Queue holds 5 entries, flush=1 -> next cycle iss_valid=0, disp_ready=1, count=0. With BR_ISSUE_QUEUE_PERF_EN, perf counters keep their values across the flush.

Source files
------------

// File: rtl/br_issue_queue.sv
// rtl/br_issue_queue.sv - in-order branch issue queue with CDB wakeup (optional perf counters: BR_ISSUE_QUEUE_PERF_EN)
module br_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int PHY_W   = 6,
    parameter int ROB_W   = 5,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [31:0]              disp_pc,
    input  logic [31:0]              disp_imm,
    input  logic [3:0]               disp_opcode,
    input  logic [ROB_W-1:0]         disp_rob_id,
    input  logic [4:0]               disp_rd_arch,
    input  logic [PHY_W-1:0]         disp_rd_phy,
    input  logic                     disp_pred_taken,
    input  logic [31:0]              disp_pred_target,
    input  logic [PHY_W-1:0]         disp_rs1_phy,
    input  logic [PHY_W-1:0]         disp_rs2_phy,
    input  logic                     disp_rs1_rdy,
    input  logic                     disp_rs2_rdy,
    input  logic [31:0]              disp_rs1_val,
    input  logic [31:0]              disp_rs2_val,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*PHY_W-1:0] cdb_phy,
    input  logic [NUM_CDB*32-1:0]    cdb_val,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [31:0]              iss_pc,
    output logic [31:0]              iss_imm,
    output logic [3:0]               iss_opcode,
    output logic [ROB_W-1:0]         iss_rob_id,
    output logic [4:0]               iss_rd_arch,
    output logic [PHY_W-1:0]         iss_rd_phy,
    output logic                     iss_pred_taken,
    output logic [31:0]              iss_pred_target,
    output logic [31:0]              iss_rs1_val,
    output logic [31:0]              iss_rs2_val,
    output logic [31:0]              perf_full_cycles,
    output logic [31:0]              perf_stall_cycles
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic              valid_q  [DEPTH];
    logic              rs1_rdy_q[DEPTH];
    logic              rs2_rdy_q[DEPTH];
    logic [PHY_W-1:0]  rs1_phy_q[DEPTH];
    logic [PHY_W-1:0]  rs2_phy_q[DEPTH];
    logic [31:0]       rs1_val_q[DEPTH];
    logic [31:0]       rs2_val_q[DEPTH];
    logic [31:0]       pc_q     [DEPTH];
    logic [31:0]       imm_q    [DEPTH];
    logic [3:0]        opcode_q [DEPTH];
    logic [ROB_W-1:0]  rob_id_q [DEPTH];
    logic [4:0]        rd_arch_q[DEPTH];
    logic [PHY_W-1:0]  rd_phy_q [DEPTH];
    logic              pt_q     [DEPTH];
    logic [31:0]       ptgt_q   [DEPTH];

    logic              w1_hit[DEPTH], w2_hit[DEPTH];
    logic [31:0]       w1_val[DEPTH], w2_val[DEPTH];
    logic              d1_hit, d2_hit, d1_rdy, d2_rdy;
    logic [31:0]       d1_cdb, d2_cdb, d1_val, d2_val;
    logic              do_disp, do_iss;

    // Bus scan runs high-to-low so the lowest-index matching bus is the one left standing.
    function automatic logic [32:0] cdb_lookup(
        input logic [PHY_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       bv,
        input logic [NUM_CDB*PHY_W-1:0] bp,
        input logic [NUM_CDB*32-1:0]    bd
    );
        logic [32:0] r;
        r = '0;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (bv[i] && bp[i*PHY_W +: PHY_W] == tag) r = {1'b1, bd[i*32 +: 32]};
        end
        return r;
    endfunction

    assign disp_ready = (count != FULL);
    assign iss_valid  = valid_q[head] && rs1_rdy_q[head] && rs2_rdy_q[head];
    assign do_disp    = disp_valid && disp_ready;
    assign do_iss     = iss_valid && iss_ready;

    assign iss_pc          = pc_q[head];
    assign iss_imm         = imm_q[head];
    assign iss_opcode      = opcode_q[head];
    assign iss_rob_id      = rob_id_q[head];
    assign iss_rd_arch     = rd_arch_q[head];
    assign iss_rd_phy      = rd_phy_q[head];
    assign iss_pred_taken  = pt_q[head];
    assign iss_pred_target = ptgt_q[head];
    assign iss_rs1_val     = rs1_val_q[head];
    assign iss_rs2_val     = rs2_val_q[head];

    // CDB tag match for every stored source and for the two dispatching sources (same-cycle bypass).
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            {w1_hit[e], w1_val[e]} = cdb_lookup(rs1_phy_q[e], cdb_valid, cdb_phy, cdb_val);
            {w2_hit[e], w2_val[e]} = cdb_lookup(rs2_phy_q[e], cdb_valid, cdb_phy, cdb_val);
        end
        {d1_hit, d1_cdb} = cdb_lookup(disp_rs1_phy, cdb_valid, cdb_phy, cdb_val);
        {d2_hit, d2_cdb} = cdb_lookup(disp_rs2_phy, cdb_valid, cdb_phy, cdb_val);
        d1_rdy = (disp_rs1_phy == '0) || disp_rs1_rdy || d1_hit;
        d2_rdy = (disp_rs2_phy == '0) || disp_rs2_rdy || d2_hit;
        d1_val = (disp_rs1_phy == '0) ? 32'h0 : (disp_rs1_rdy ? disp_rs1_val : d1_cdb);
        d2_val = (disp_rs2_phy == '0) ? 32'h0 : (disp_rs2_rdy ? disp_rs2_val : d2_cdb);
    end

    // Control state: pointers, count, valid and ready bits; flush wipes everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                valid_q[e]   <= 1'b0;
                rs1_rdy_q[e] <= 1'b0;
                rs2_rdy_q[e] <= 1'b0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (valid_q[e] && !rs1_rdy_q[e] && w1_hit[e]) rs1_rdy_q[e] <= 1'b1;
                if (valid_q[e] && !rs2_rdy_q[e] && w2_hit[e]) rs2_rdy_q[e] <= 1'b1;
            end
            if (do_iss) begin
                valid_q[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (do_disp) begin
                valid_q[tail]   <= 1'b1;
                rs1_rdy_q[tail] <= d1_rdy;
                rs2_rdy_q[tail] <= d2_rdy;
                tail            <= tail + PTR_W'(1);
            end
            case ({do_disp, do_iss})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload and captured operand values; no reset needed since valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (valid_q[e] && !rs1_rdy_q[e] && w1_hit[e]) rs1_val_q[e] <= w1_val[e];
                if (valid_q[e] && !rs2_rdy_q[e] && w2_hit[e]) rs2_val_q[e] <= w2_val[e];
            end
            if (do_disp) begin
                pc_q[tail]      <= disp_pc;
                imm_q[tail]     <= disp_imm;
                opcode_q[tail]  <= disp_opcode;
                rob_id_q[tail]  <= disp_rob_id;
                rd_arch_q[tail] <= disp_rd_arch;
                rd_phy_q[tail]  <= disp_rd_phy;
                pt_q[tail]      <= disp_pred_taken;
                ptgt_q[tail]    <= disp_pred_target;
                rs1_phy_q[tail] <= disp_rs1_phy;
                rs2_phy_q[tail] <= disp_rs2_phy;
                rs1_val_q[tail] <= d1_val;
                rs2_val_q[tail] <= d2_val;
            end
        end
    end

`ifdef BR_ISSUE_QUEUE_PERF_EN
    logic [31:0] full_cnt, stall_cnt;

    // Occupancy counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (count == FULL) full_cnt <= full_cnt + 32'd1;
            if (valid_q[head] && !(rs1_rdy_q[head] && rs2_rdy_q[head])) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_full_cycles  = full_cnt;
    assign perf_stall_cycles = stall_cnt;
`else
    assign perf_full_cycles  = 32'h0;
    assign perf_stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_br_issue_queue.sv
// tb/tb_br_issue_queue.sv - randomized bench for br_issue_queue against a uop-list model
module tb_br_issue_queue;
    localparam int DEPTH   = 8;
    localparam int PHY_W   = 6;
    localparam int ROB_W   = 5;
    localparam int NUM_CDB = 2;

    logic clk = 1'b0;
    logic rst, flush, disp_valid, disp_ready;
    logic [31:0] disp_pc, disp_imm, disp_pred_target, disp_rs1_val, disp_rs2_val;
    logic [3:0] disp_opcode;
    logic [ROB_W-1:0] disp_rob_id;
    logic [4:0] disp_rd_arch;
    logic [PHY_W-1:0] disp_rd_phy, disp_rs1_phy, disp_rs2_phy;
    logic disp_pred_taken, disp_rs1_rdy, disp_rs2_rdy;
    logic [NUM_CDB-1:0] cdb_valid;
    logic [NUM_CDB*PHY_W-1:0] cdb_phy;
    logic [NUM_CDB*32-1:0] cdb_val;
    logic iss_valid, iss_ready, iss_pred_taken;
    logic [31:0] iss_pc, iss_imm, iss_pred_target, iss_rs1_val, iss_rs2_val;
    logic [3:0] iss_opcode;
    logic [ROB_W-1:0] iss_rob_id;
    logic [4:0] iss_rd_arch;
    logic [PHY_W-1:0] iss_rd_phy;
    logic [31:0] perf_full_cycles, perf_stall_cycles;

    br_issue_queue #(.DEPTH(DEPTH), .PHY_W(PHY_W), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_opcode(disp_opcode),
        .disp_rob_id(disp_rob_id), .disp_rd_arch(disp_rd_arch), .disp_rd_phy(disp_rd_phy),
        .disp_pred_taken(disp_pred_taken), .disp_pred_target(disp_pred_target),
        .disp_rs1_phy(disp_rs1_phy), .disp_rs2_phy(disp_rs2_phy),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
        .cdb_valid(cdb_valid), .cdb_phy(cdb_phy), .cdb_val(cdb_val),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_opcode(iss_opcode), .iss_rob_id(iss_rob_id),
        .iss_rd_arch(iss_rd_arch), .iss_rd_phy(iss_rd_phy), .iss_pred_taken(iss_pred_taken),
        .iss_pred_target(iss_pred_target), .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
        .perf_full_cycles(perf_full_cycles), .perf_stall_cycles(perf_stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, imm, ptgt, v1, v2;
        logic [3:0]  op;
        logic [ROB_W-1:0] rob;
        logic [PHY_W-1:0] rdp, p1, p2;
        logic r1, r2;
    } uop_t;

    uop_t mq[$];
    int unsigned m_full, m_stall;
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // First valid bus in index order carrying the tag supplies the value.
    function automatic logic bus_hit(input logic [PHY_W-1:0] tag, output logic [31:0] v);
        v = 32'h0;
        for (int i = 0; i < NUM_CDB; i++)
            if (cdb_valid[i] && cdb_phy[i*PHY_W +: PHY_W] == tag) begin
                v = cdb_val[i*32 +: 32];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic logic head_ready();
        return mq.size() > 0 && mq[0].r1 && mq[0].r2;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        uop_t u;
        logic [31:0] v;
        logic take;
        if (rst) begin
            mq.delete();
            m_full = 0;
            m_stall = 0;
            return;
        end
        if (mq.size() == DEPTH) m_full++;
        if (mq.size() > 0 && !head_ready()) m_stall++;
        if (flush) begin
            mq.delete();
            return;
        end
        take = head_ready() && iss_ready;
        for (int k = 0; k < mq.size(); k++) begin
            if (!mq[k].r1 && bus_hit(mq[k].p1, v)) begin mq[k].r1 = 1'b1; mq[k].v1 = v; end
            if (!mq[k].r2 && bus_hit(mq[k].p2, v)) begin mq[k].r2 = 1'b1; mq[k].v2 = v; end
        end
        if (take) void'(mq.pop_front());
        if (disp_valid && (mq.size() + (take ? 1 : 0)) != DEPTH) begin
            u.pc = disp_pc; u.imm = disp_imm; u.ptgt = disp_pred_target; u.op = disp_opcode;
            u.rob = disp_rob_id; u.rdp = disp_rd_phy; u.p1 = disp_rs1_phy; u.p2 = disp_rs2_phy;
            if (disp_rs1_phy == 0) begin u.r1 = 1; u.v1 = 0; end
            else if (disp_rs1_rdy) begin u.r1 = 1; u.v1 = disp_rs1_val; end
            else begin u.r1 = bus_hit(disp_rs1_phy, v); u.v1 = v; end
            if (disp_rs2_phy == 0) begin u.r2 = 1; u.v2 = 0; end
            else if (disp_rs2_rdy) begin u.r2 = 1; u.v2 = disp_rs2_val; end
            else begin u.r2 = bus_hit(disp_rs2_phy, v); u.v2 = v; end
            mq.push_back(u);
        end
    endtask

    task automatic compare_all();
        logic ev;
        ev = head_ready();
        check("iss_valid", {31'b0, iss_valid}, {31'b0, ev});
        check("disp_ready", {31'b0, disp_ready}, {31'b0, mq.size() != DEPTH});
        if (ev && iss_valid) begin
            check("iss_pc", iss_pc, mq[0].pc);
            check("iss_imm", iss_imm, mq[0].imm);
            check("iss_opcode", {28'b0, iss_opcode}, {28'b0, mq[0].op});
            check("iss_rob_id", {27'b0, iss_rob_id}, {27'b0, mq[0].rob});
            check("iss_rd_phy", {26'b0, iss_rd_phy}, {26'b0, mq[0].rdp});
            check("iss_pred_target", iss_pred_target, mq[0].ptgt);
            check("iss_rs1_val", iss_rs1_val, mq[0].v1);
            check("iss_rs2_val", iss_rs2_val, mq[0].v2);
        end
`ifdef BR_ISSUE_QUEUE_PERF_EN
        check("perf_full", perf_full_cycles, m_full);
        check("perf_stall", perf_stall_cycles, m_stall);
`else
        check("perf_full", perf_full_cycles, 32'h0);
        check("perf_stall", perf_stall_cycles, 32'h0);
`endif
    endtask

    // Caller sets inputs at the falling edge; model and DUT both take one edge, then compare.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        rst = 0; flush = 0; disp_valid = 0; iss_ready = 0; cdb_valid = '0;
        cdb_phy = '0; cdb_val = '0;
        disp_pc = 0; disp_imm = 0; disp_opcode = 0; disp_rob_id = 0; disp_rd_arch = 0;
        disp_rd_phy = 0; disp_pred_taken = 0; disp_pred_target = 0;
        disp_rs1_phy = 0; disp_rs2_phy = 0; disp_rs1_rdy = 0; disp_rs2_rdy = 0;
        disp_rs1_val = 0; disp_rs2_val = 0;
    endtask

    task automatic random_inputs(input int disp_pct, input int iss_pct, input int flush_per_mille);
        rst = 0;
        flush = ($urandom_range(999) < flush_per_mille);
        disp_valid = ($urandom_range(99) < disp_pct);
        iss_ready = ($urandom_range(99) < iss_pct);
        disp_pc = $urandom; disp_imm = $urandom; disp_opcode = 4'($urandom);
        disp_rob_id = ROB_W'($urandom); disp_rd_arch = 5'($urandom);
        disp_rd_phy = PHY_W'($urandom); disp_pred_taken = 1'($urandom);
        disp_pred_target = $urandom;
        disp_rs1_phy = PHY_W'($urandom_range(7)); disp_rs2_phy = PHY_W'($urandom_range(7));
        disp_rs1_rdy = ($urandom_range(99) < 40); disp_rs2_rdy = ($urandom_range(99) < 40);
        disp_rs1_val = $urandom; disp_rs2_val = $urandom;
        for (int i = 0; i < NUM_CDB; i++) begin
            cdb_valid[i] = ($urandom_range(99) < 35);
            cdb_phy[i*PHY_W +: PHY_W] = PHY_W'($urandom_range(7, 1));
            cdb_val[i*32 +: 32] = $urandom;
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        cycle();
        cycle();
        rst = 0;
        cycle();

        // Both operands ready at dispatch: visible at the issue port one edge later.
        disp_valid = 1; disp_pc = 32'h100; disp_opcode = 4'h0;
        disp_rs1_phy = 6'd3; disp_rs2_phy = 6'd4; disp_rs1_rdy = 1; disp_rs2_rdy = 1;
        disp_rs1_val = 32'h11; disp_rs2_val = 32'h22; iss_ready = 1;
        cycle();
        check("dir_beq_valid", {31'b0, iss_valid}, 32'h1);
        check("dir_beq_pc", iss_pc, 32'h100);
        disp_valid = 0;
        cycle();
        check("dir_empty", {31'b0, iss_valid}, 32'h0);

        // Same-cycle bypass from bus 0 onto a not-ready rs2.
        disp_valid = 1; disp_pc = 32'h200; disp_rs2_phy = 6'd7; disp_rs2_rdy = 0;
        cdb_valid = 2'b01; cdb_phy = {6'd0, 6'd7}; cdb_val = {32'h0, 32'h55};
        cycle();
        check("dir_bypass_rs2", iss_rs2_val, 32'h55);
        idle_inputs();
        iss_ready = 1;
        cycle();

        for (int n = 0; n < 3000; n++) begin
            case ((n / 150) % 4)
                0: random_inputs(90, 10, 5);
                1: random_inputs(50, 90, 5);
                2: random_inputs(80, 60, 20);
                default: random_inputs(70, 70, 0);
            endcase
            cycle();
        end

        // Fill completely with issue blocked, then flush with several entries held.
        idle_inputs();
        for (int n = 0; n < DEPTH + 2; n++) begin
            random_inputs(100, 0, 0);
            disp_rs1_rdy = 1; disp_rs2_rdy = 1;
            cycle();
        end
        check("dir_full", {31'b0, disp_ready}, 32'h0);
        idle_inputs();
        flush = 1;
        cycle();
        check("dir_flush_ready", {31'b0, disp_ready}, 32'h1);
        check("dir_flush_valid", {31'b0, iss_valid}, 32'h0);
        idle_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
